pipe_add: RTL and testbench
===========================

Name: pipe_add

Overview:
Parametrised, pipelined successor to the combinational full adder. Splits a WIDTH-bit add/subtract into STAGES carry-chained chunk additions, one chunk per clock stage. Valid/ready handshake on both sides, with backpressure. Reports carry-out and signed overflow. Serves as the arithmetic datapath element for the next generation of testbench-driven designs, where wide operands must meet timing.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..64.
STAGES, 2, number of pipeline stages; legal range 1..WIDTH; WIDTH % STAGES must equal 0. Elaboration fails otherwise.

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  reset; one clock, synchronous, active-high
in_valid  input  1  operand bundle present
in_ready  output  1  block accepts the bundle this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
c_in  input  1  carry-in; ignored when sub=1
sub  input  1  0: a+b+c_in; 1: a-b, computed as a+~b+1
out_valid  output  1  result present
out_ready  input  1  consumer accepts the result
sum  output  WIDTH  result, modulo 2^WIDTH
c_out  output  1  carry out of the MSB; for sub, 1 means no borrow (a>=b unsigned)
ovf  output  1  signed two's-complement overflow

Behaviour:
- CHUNK = WIDTH/STAGES. Stage k (0..STAGES-1) adds bits [k*CHUNK +: CHUNK] plus the registered carry from stage k-1. Stage 0 uses c_in, or 1 when sub=1.
- Operand chunks not yet consumed travel in skew registers. Completed sum chunks travel in de-skew registers, so all chunks of one operation emerge together.
- B is inverted at stage 0 entry when sub=1. The sub flag is not needed downstream.
- ovf = carry into MSB XOR carry out of MSB. It is computed in the last stage.
- Advance condition: adv = !out_valid || out_ready. When adv=1 every stage register, including valid bits, shifts one stage. When adv=0 all stage registers hold.
- in_ready = adv, combinational from out_valid/out_ready. There is no combinational path from in_valid to in_ready.
- Transfer in = in_valid && in_ready. Transfer out = out_valid && out_ready.
- Latency: exactly STAGES cycles from accept to out_valid when no stall. Throughput is 1 op/cycle while out_ready=1.
- Bubbles (in_valid=0 while adv=1) propagate as invalid slots. Bubbles are not collapsed.
- While out_valid=1 && out_ready=0: sum, c_out and ovf hold stable, and out_valid stays 1.
- Ordering: results leave in acceptance order. No drop or duplication under any stall pattern.
- With STAGES=1 the block is a single registered add with the same handshake.
- Reset: when rst=1 at a rising edge, all valid bits clear and all data registers clear. After that edge out_valid=0, sum=0, c_out=0, ovf=0, and in_ready=1.
- Reset mid-operation discards in-flight operations. rst has priority over adv and over in_valid.
- Data registers with valid=0 may hold stale values internally, but the outputs are 0 only immediately after reset. Benches check data only when out_valid=1.
- Overflow wrap: sum wraps modulo 2^WIDTH. c_out and ovf report it and have no other effect.

Decomposition:
- Shared package pipe_add_pkg:
  - default WIDTH/STAGES constants;
  - a constant function computing CHUNK;
  - the legality check used by the elaboration assertion.
- Sub-module pipe_add_stage, instantiated STAGES times via generate. It contains:
  - one CHUNK-bit adder;
  - its carry register;
  - its valid bit;
  - its slice of the skew and de-skew registers;
  - the hold-on-!adv enable.
- The top level holds only the handshake logic and the ovf computation.

Test Plan:
1. Reset (WIDTH=8, STAGES=2): hold rst=1 for 2 cycles, then release -> out_valid=0, sum=0x00, c_out=0, ovf=0, in_ready=1 on the first cycle after release.
2. Cross-chunk carry: a=0xFF, b=0x01, c_in=0, sub=0, out_ready=1 -> exactly 2 cycles later out_valid=1, sum=0x00, c_out=1, ovf=0.
3. Signed overflow and subtract:
   - a=0x7F, b=0x01 -> sum=0x80, c_out=0, ovf=1.
   - next cycle a=0x05, b=0x07, sub=1 -> sum=0xFE, c_out=0, ovf=0.
   - both results appear on consecutive cycles.
4. Backpressure: issue 4 back-to-back ops (1+1, 2+2, 3+3, 4+4). Drop out_ready for 3 cycles as the first result appears -> in_ready=0 during the stall, sum holds 0x02, and the results then follow as 0x02, 0x04, 0x06, 0x08 with no loss or duplicate.
5. Reset mid-stream: assert rst while 2 ops are in flight -> out_valid=0 the cycle after, and no stale result emerges afterward. A new op 0x10+0x20 yields 0x30 after 2 cycles.
6. Parameter sweep: build WIDTH=8/STAGES=1, WIDTH=8/STAGES=8 and WIDTH=32/STAGES=4. Apply 1000 random ops with random out_ready -> every result matches the reference model (a+b+c_in or a-b, c_out, ovf), and latency equals STAGES whenever there is no stall.

Source files
------------

// File: rtl/pipe_add_pkg.sv
// Shared constants and elaboration helpers for the pipelined adder.
package pipe_add_pkg;

   localparam int DEF_WIDTH  = 8;
   localparam int DEF_STAGES = 2;

   function automatic int chunk_width(input int width, input int stages);
      return (stages > 0) ? (width / stages) : 1;
   endfunction

   function automatic bit params_legal(input int width, input int stages);
      return (width >= 2) && (width <= 64) && (stages >= 1) && (stages <= width)
             && ((width % stages) == 0);
   endfunction

endpackage

// File: rtl/pipe_add_stage.sv
// One pipeline stage: adds chunk IDX with the carry from the previous stage and
// forwards the skewed operands and the partially assembled sum.
module pipe_add_stage
   import pipe_add_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CHUNK = chunk_width(DEF_WIDTH, DEF_STAGES),
   parameter int IDX   = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             adv,
   input  logic             valid_i,
   input  logic             carry_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [WIDTH-1:0] sum_i,
   output logic             valid_o,
   output logic             carry_o,
   output logic             msb_cin_o,
   output logic [WIDTH-1:0] a_o,
   output logic [WIDTH-1:0] b_o,
   output logic [WIDTH-1:0] sum_o
);

   localparam int LO = IDX * CHUNK;
   localparam int HI = LO + CHUNK - 1;

   logic [CHUNK:0]   chunk_res;
   logic             valid_d, valid_q;
   logic             carry_d, carry_q;
   logic             msb_cin_d, msb_cin_q;
   logic [WIDTH-1:0] a_d, a_q;
   logic [WIDTH-1:0] b_d, b_q;
   logic [WIDTH-1:0] sum_d, sum_q;

   always_comb begin
      chunk_res = {1'b0, a_i[LO +: CHUNK]} + {1'b0, b_i[LO +: CHUNK]}
                  + {{CHUNK{1'b0}}, carry_i};
      valid_d   = valid_q;
      carry_d   = carry_q;
      msb_cin_d = msb_cin_q;
      a_d       = a_q;
      b_d       = b_q;
      sum_d     = sum_q;
      if (adv) begin
         valid_d   = valid_i;
         carry_d   = chunk_res[CHUNK];
         // Carry into the chunk's top bit, recovered from the sum bit.
         msb_cin_d = a_i[HI] ^ b_i[HI] ^ chunk_res[CHUNK-1];
         a_d       = a_i;
         b_d       = b_i;
         sum_d     = sum_i;
         sum_d[LO +: CHUNK] = chunk_res[CHUNK-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q   <= 1'b0;
         carry_q   <= 1'b0;
         msb_cin_q <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         sum_q     <= '0;
      end else begin
         valid_q   <= valid_d;
         carry_q   <= carry_d;
         msb_cin_q <= msb_cin_d;
         a_q       <= a_d;
         b_q       <= b_d;
         sum_q     <= sum_d;
      end
   end

   assign valid_o   = valid_q;
   assign carry_o   = carry_q;
   assign msb_cin_o = msb_cin_q;
   assign a_o       = a_q;
   assign b_o       = b_q;
   assign sum_o     = sum_q;

endmodule

// File: rtl/pipe_add.sv
// Pipelined WIDTH-bit add/subtract with valid/ready handshake, carry-out and
// signed overflow; the carry ripples one CHUNK-bit slice per stage.
module pipe_add
   import pipe_add_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STAGES = DEF_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf
);

   localparam int CHUNK = chunk_width(WIDTH, STAGES);

   if (!params_legal(WIDTH, STAGES)) begin : g_bad_params
      $error("pipe_add: illegal WIDTH/STAGES combination");
   end

   logic             adv;
   logic [STAGES:0]  valid_p;
   logic [STAGES:0]  carry_p;
   logic [STAGES:1]  msb_cin_p;
   logic [WIDTH-1:0] a_p   [STAGES+1];
   logic [WIDTH-1:0] b_p   [STAGES+1];
   logic [WIDTH-1:0] sum_p [STAGES+1];

   // The whole pipe moves as one; it only freezes when the result is refused.
   assign adv      = !valid_p[STAGES] || out_ready;
   assign in_ready = adv;

   assign valid_p[0] = in_valid;
   assign carry_p[0] = sub | c_in;
   assign a_p[0]     = a;
   assign b_p[0]     = sub ? ~b : b;
   assign sum_p[0]   = '0;

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      pipe_add_stage #(
         .WIDTH (WIDTH),
         .CHUNK (CHUNK),
         .IDX   (gi)
      ) u_stage (
         .clk       (clk),
         .rst       (rst),
         .adv       (adv),
         .valid_i   (valid_p[gi]),
         .carry_i   (carry_p[gi]),
         .a_i       (a_p[gi]),
         .b_i       (b_p[gi]),
         .sum_i     (sum_p[gi]),
         .valid_o   (valid_p[gi+1]),
         .carry_o   (carry_p[gi+1]),
         .msb_cin_o (msb_cin_p[gi+1]),
         .a_o       (a_p[gi+1]),
         .b_o       (b_p[gi+1]),
         .sum_o     (sum_p[gi+1])
      );
   end

   assign out_valid = valid_p[STAGES];
   assign sum       = sum_p[STAGES];
   assign c_out     = carry_p[STAGES];
   assign ovf       = msb_cin_p[STAGES] ^ carry_p[STAGES];

   // Operands leaving the last stage and early-stage MSB carries have no consumer.
   logic unused_pipe;
   assign unused_pipe = ^{msb_cin_p, a_p[STAGES], b_p[STAGES]};

endmodule

// File: tb/tb_pipe_add.sv
// Directed handshake tests on an 8/2 pipe_add plus randomized checks of three
// other configurations against an arithmetic reference model.
module tb_pipe_add;

   typedef struct {
      longint unsigned a;
      longint unsigned b;
      bit              sub;
      longint unsigned s;
      bit              co;
      bit              ov;
      int              cyc;
      int              stl;
   } exp_t;

   localparam int NOPS = 1000;

   logic clk;
   logic rst;
   bit   rnd_go;
   int   n_checks;
   int   n_fail;

   logic       in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out, ovf;
   logic [7:0] a, b, sum;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic void ref_model(input int w, input longint unsigned ua, input longint unsigned ub,
                                     input bit cin, input bit bsub, output longint unsigned s,
                                     output bit co, output bit ov);
      longint unsigned modv;
      longint          half, sa, sb, t;
      modv = 64'd1 << w;
      half = longint'(modv >> 1);
      sa   = (ua >= (modv >> 1)) ? longint'(ua) - longint'(modv) : longint'(ua);
      sb   = (ub >= (modv >> 1)) ? longint'(ub) - longint'(modv) : longint'(ub);
      if (bsub) begin
         co = (ua >= ub);
         s  = (ua - ub) & (modv - 1);
         t  = sa - sb;
      end else begin
         co = ((ua + ub + 64'(cin)) >= modv);
         s  = (ua + ub + 64'(cin)) & (modv - 1);
         t  = sa + sb + longint'(cin);
      end
      ov = (t < -half) || (t >= half);
   endfunction

   function automatic int cfg_w(input int i);
      return (i == 2) ? 32 : 8;
   endfunction

   function automatic int cfg_s(input int i);
      return (i == 0) ? 1 : ((i == 1) ? 8 : 4);
   endfunction

   pipe_add #(.WIDTH(8), .STAGES(2)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c_in      (c_in),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .c_out     (c_out),
      .ovf       (ovf)
   );

   for (genvar gi = 0; gi < 3; gi++) begin : g_rnd
      localparam int W = cfg_w(gi);
      localparam int S = cfg_s(gi);

      logic         r_in_valid, r_in_ready, r_c_in, r_sub, r_out_valid, r_out_ready, r_c_out, r_ovf;
      logic [W-1:0] r_a, r_b, r_sum;
      bit           done;

      pipe_add #(.WIDTH(W), .STAGES(S)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (r_in_valid),
         .in_ready  (r_in_ready),
         .a         (r_a),
         .b         (r_b),
         .c_in      (r_c_in),
         .sub       (r_sub),
         .out_valid (r_out_valid),
         .out_ready (r_out_ready),
         .sum       (r_sum),
         .c_out     (r_c_out),
         .ovf       (r_ovf)
      );

      initial begin
         exp_t         q[$];
         exp_t         e;
         int           accepted, cyc, stalls;
         bit           seen, hold;
         logic [W-1:0] hsum;
         done        = 1'b0;
         r_in_valid  = 1'b0;
         r_out_ready = 1'b1;
         r_a         = '0;
         r_b         = '0;
         r_c_in      = 1'b0;
         r_sub       = 1'b0;
         accepted    = 0;
         cyc         = 0;
         stalls      = 0;
         seen        = 1'b0;
         hold        = 1'b0;
         hsum        = '0;
         wait (rnd_go);
         while ((accepted < NOPS || q.size() != 0) && cyc < 30000) begin
            @(negedge clk);
            cyc++;
            if (hold) begin
               check("rnd_hold_valid", 64'(r_out_valid), 64'd1);
               check("rnd_hold_sum", 64'(r_sum), 64'(hsum));
            end
            if (r_out_valid && !seen && q.size() != 0) begin
               check("rnd_latency", 64'(cyc - q[0].cyc), 64'(S + stalls - q[0].stl));
               seen = 1'b1;
            end
            r_out_ready = (accepted >= NOPS) ? 1'b1 : ($urandom_range(3) != 0);
            r_in_valid  = (accepted < NOPS) && ($urandom_range(3) != 0);
            r_a         = W'($urandom());
            r_b         = W'($urandom());
            r_c_in      = 1'($urandom_range(1));
            r_sub       = 1'($urandom_range(1));
            #1;
            check("rnd_in_ready", 64'(r_in_ready), 64'(!r_out_valid || r_out_ready));
            hold = r_out_valid && !r_out_ready;
            hsum = r_sum;
            if (!r_in_ready) stalls++;
            if (r_out_valid && r_out_ready) begin
               if (q.size() == 0) begin
                  check("rnd_dup", 64'(r_out_valid), 64'd0);
               end else begin
                  e = q.pop_front();
                  check("rnd_sum", 64'(r_sum), e.s);
                  check("rnd_c_out", 64'(r_c_out), 64'(e.co));
                  check("rnd_ovf", 64'(r_ovf), 64'(e.ov));
                  $display("W=%0d S=%0d: 0x%0h %s 0x%0h -> sum=0x%0h c_out=%0b ovf=%0b",
                           W, S, e.a, e.sub ? "-" : "+", e.b, r_sum, r_c_out, r_ovf);
                  seen = 1'b0;
               end
            end
            if (r_in_valid && r_in_ready) begin
               e.a   = 64'(r_a);
               e.b   = 64'(r_b);
               e.sub = r_sub;
               ref_model(W, 64'(r_a), 64'(r_b), r_c_in, r_sub, e.s, e.co, e.ov);
               e.cyc = cyc;
               e.stl = stalls;
               q.push_back(e);
               accepted++;
            end
         end
         check("rnd_accepted", 64'(accepted), 64'(NOPS));
         check("rnd_drained", 64'(q.size()), 64'd0);
         done = 1'b1;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int idx, k;
      n_checks  = 0;
      n_fail    = 0;
      rnd_go    = 1'b0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      c_in      = 1'b0;
      sub       = 1'b0;
      out_ready = 1'b1;

      // Reset held for two edges
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_sum", 64'(sum), 64'd0);
      check("rst_c_out", 64'(c_out), 64'd0);
      check("rst_ovf", 64'(ovf), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);

      // Cross-chunk carry
      a = 8'hFF; b = 8'h01; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("carry_early", 64'(out_valid), 64'd0);
      @(negedge clk);
      check("carry_valid", 64'(out_valid), 64'd1);
      check("carry_sum", 64'(sum), 64'h00);
      check("carry_c_out", 64'(c_out), 64'd1);
      check("carry_ovf", 64'(ovf), 64'd0);
      $display("8/2: 0xff + 0x01 -> sum=0x%0h c_out=%0b ovf=%0b", sum, c_out, ovf);

      // Signed overflow then subtract, back to back
      @(negedge clk);
      a = 8'h7F; b = 8'h01; sub = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      a = 8'h05; b = 8'h07; sub = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; sub = 1'b0;
      check("ovf_valid", 64'(out_valid), 64'd1);
      check("ovf_sum", 64'(sum), 64'h80);
      check("ovf_c_out", 64'(c_out), 64'd0);
      check("ovf_ovf", 64'(ovf), 64'd1);
      $display("8/2: 0x7f + 0x01 -> sum=0x%0h c_out=%0b ovf=%0b", sum, c_out, ovf);
      @(negedge clk);
      check("sub_valid", 64'(out_valid), 64'd1);
      check("sub_sum", 64'(sum), 64'hFE);
      check("sub_c_out", 64'(c_out), 64'd0);
      check("sub_ovf", 64'(ovf), 64'd0);
      $display("8/2: 0x05 - 0x07 -> sum=0x%0h c_out=%0b ovf=%0b", sum, c_out, ovf);

      // Backpressure: first result stalled for three cycles
      idx = 0;
      k   = 0;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         out_ready = !(c >= 2 && c < 5);
         in_valid  = (idx < 4);
         a         = 8'(idx + 1);
         b         = 8'(idx + 1);
         #1;
         if (k >= 4) begin
            check("bp_extra", 64'(out_valid), 64'd0);
         end else if (out_valid) begin
            if (!out_ready) begin
               check("bp_stall_ready", 64'(in_ready), 64'd0);
               check("bp_hold_sum", 64'(sum), 64'h02);
            end else begin
               check("bp_sum", 64'(sum), 64'(2 * (k + 1)));
               $display("8/2: backpressure result %0d -> sum=0x%0h", k, sum);
               k++;
            end
         end
         if (in_valid && in_ready) idx++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("bp_count", 64'(k), 64'd4);

      // Reset with two operations in flight
      @(negedge clk);
      a = 8'h11; b = 8'h11; in_valid = 1'b1;
      @(negedge clk);
      a = 8'h22; b = 8'h22;
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rstmid_valid", 64'(out_valid), 64'd0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("rstmid_no_stale", 64'(out_valid), 64'd0);
      end
      a = 8'h10; b = 8'h20; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("rstmid_early", 64'(out_valid), 64'd0);
      @(negedge clk);
      check("rstmid_new_valid", 64'(out_valid), 64'd1);
      check("rstmid_new_sum", 64'(sum), 64'h30);
      $display("8/2: 0x10 + 0x20 after reset -> sum=0x%0h", sum);

      // Randomized configurations run in parallel
      rnd_go = 1'b1;
      wait (g_rnd[0].done && g_rnd[1].done && g_rnd[2].done);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
